// File: rtl/mux_channel_arbiter_if.sv
// Channel bundle between two producers, the arbiter and one downstream consumer.
// The master modport is the arbiter's side and the slave modport is the environment's side.
interface mux_channel_arbiter_if #(
  parameter int N_BITS = 8
);
  // Handshake: a beat transfers on any rising clk edge where Out_Valid and Out_Ready are both high.
  // Ack_x is high in exactly that cycle for the granted requester. Data_x must stay stable while
  // Req_x=1 and Ack_x=0, and Req_x may be dropped after any Ack_x.
  logic              Req_0;
  logic [N_BITS-1:0] Data_0;
  logic              Ack_0;
  logic              Req_1;
  logic [N_BITS-1:0] Data_1;
  logic              Ack_1;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [N_BITS-1:0] Out_Data;

  modport master (
    input  Req_0, Data_0, Req_1, Data_1, Out_Ready,
    output Ack_0, Ack_1, Out_Valid, Out_Data
  );

  modport slave (
    output Req_0, Data_0, Req_1, Data_1, Out_Ready,
    input  Ack_0, Ack_1, Out_Valid, Out_Data
  );
endinterface

// File: rtl/mux_channel_arbiter.sv
// Two-requester arbiter that drives the select of a 2:1 datapath mux, with burst-limited grants.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; leave it undefined for fixed priority (requester 0 wins).
module mux_channel_arbiter #(
  parameter int N_BITS    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  mux_channel_arbiter_if.master              ch,
  output logic                               Grant_Id,
  output logic                               Busy,
  output logic [1:0]                         state_dbg,
  output logic [$clog2(MAX_BURST+1)-1:0]     beat_cnt_dbg
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               grant_id_q, grant_id_d;
  logic               busy_q, busy_d;

  logic               out_valid;
  logic               beat;
  logic               pick_1;
  logic [CNT_W-1:0]   cnt_inc;
  logic               burst_done;

  // Datapath outputs are combinational from registered state, so a grant serves a beat the cycle it starts.
  always_comb begin
    unique case (state_q)
      GNT0:    out_valid = ch.Req_0;
      GNT1:    out_valid = ch.Req_1;
      default: out_valid = 1'b0;
    endcase
  end

  assign beat        = out_valid & ch.Out_Ready;
  assign ch.Out_Valid = out_valid;
  assign ch.Ack_0    = beat & (state_q == GNT0);
  assign ch.Ack_1    = beat & (state_q == GNT1);
  assign ch.Out_Data = grant_id_q ? ch.Data_1 : ch.Data_0;
  assign Grant_Id    = grant_id_q;
  assign Busy        = busy_q;
  assign state_dbg   = state_q;
  assign beat_cnt_dbg = beat_cnt_q;

  assign cnt_inc    = beat_cnt_q + 1'b1;
  assign burst_done = (cnt_inc == CNT_W'(MAX_BURST));

  always_comb begin
    if (ch.Req_0 && ch.Req_1) pick_1 = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    else                      pick_1 = ch.Req_1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ch.Req_0 || ch.Req_1) begin
          state_d      = pick_1 ? GNT1 : GNT0;
          last_grant_d = pick_1;
          beat_cnt_d   = '0;
        end
      end
      GNT0: begin
        if (!ch.Req_0) begin
          state_d    = ch.Req_1 ? GNT1 : IDLE;
          if (ch.Req_1) last_grant_d = 1'b1;
          beat_cnt_d = '0;
        end else if (beat) begin
          // Fixed priority keeps counting (wrapping at MAX_BURST) but never yields requester 0's grant.
          if (burst_done) begin
            beat_cnt_d = '0;
            if (ch.Req_1 && ROUND_ROBIN) begin
              state_d      = GNT1;
              last_grant_d = 1'b1;
            end
          end else begin
            beat_cnt_d = cnt_inc;
          end
        end
      end
      GNT1: begin
        if (!ch.Req_1) begin
          state_d    = ch.Req_0 ? GNT0 : IDLE;
          if (ch.Req_0) last_grant_d = 1'b0;
          beat_cnt_d = '0;
        end else if (beat) begin
          if (burst_done) begin
            beat_cnt_d = '0;
            if (ch.Req_0) begin
              state_d      = GNT0;
              last_grant_d = 1'b0;
            end
          end else begin
            beat_cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  assign grant_id_d = (state_d == GNT1);
  assign busy_d     = (state_d != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      grant_id_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
    end
  end
endmodule

// File: tb/tb_mux_channel_arbiter.sv
// Bench for mux_channel_arbiter: vector table plus hand-written contention and reset sequences,
// with a beat scoreboard of {grant, data}. Expectations follow ARB_ROUND_ROBIN_EN if it is defined.
module tb_mux_channel_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       grant_id;
  logic       busy;
  logic [1:0] state_dbg;
  logic [2:0] beat_cnt_dbg;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic        r0;
    logic        r1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  mux_channel_arbiter_if #(.N_BITS(8)) ch();

  mux_channel_arbiter #(.N_BITS(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ch           (ch),
    .Grant_Id     (grant_id),
    .Busy         (busy),
    .state_dbg    (state_dbg),
    .beat_cnt_dbg (beat_cnt_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic v, input logic a0, input logic a1,
                                     input logic g, input logic b, input logic [2:0] c,
                                     input logic [7:0] d);
    return {v, a0, a1, g, b, c, d};
  endfunction

  // driver tasks
  task automatic drive(input logic r0, input logic r1, input logic [7:0] d0,
                       input logic [7:0] d1, input logic rdy);
    ch.Req_0     = r0;
    ch.Req_1     = r1;
    ch.Data_0    = d0;
    ch.Data_1    = d1;
    ch.Out_Ready = rdy;
  endtask

  task automatic add(input logic r0, input logic r1, input logic [7:0] d0,
                     input logic [7:0] d1, input logic rdy, input logic [15:0] e);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] e);
    logic [15:0] act;
    act = {ch.Out_Valid, ch.Ack_0, ch.Ack_1, grant_id, busy, beat_cnt_dbg, ch.Out_Data};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: {valid,ack0,ack1,gid,busy,cnt,data} got=%h want=%h", name, act, e);
    end
  endtask

  task automatic expect_beat(input logic [15:0] e);
    if (e[14]) exp_q.push_back({1'b0, e[7:0]});
    if (e[13]) exp_q.push_back({1'b1, e[7:0]});
  endtask

  // scoreboard: every transferred beat pops and compares {grant, data}
  task automatic monitor_beat(input string name);
    logic [8:0] want;
    if (ch.Out_Valid && ch.Out_Ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s beat: got={%b,%h} want=none", name, grant_id, ch.Out_Data);
      end else begin
        want = exp_q.pop_front();
        if ({grant_id, ch.Out_Data} !== want) begin
          bad++;
          $display("FAIL %s beat: got={%b,%h} want={%b,%h}", name, grant_id, ch.Out_Data,
                   want[8], want[7:0]);
        end
      end
    end
  endtask

  task automatic step(input string name, input logic r0, input logic r1, input logic [7:0] d0,
                      input logic [7:0] d1, input logic rdy, input logic [15:0] e);
    drive(r0, r1, d0, d1, rdy);
    #3;
    expect_beat(e);
    check(name, e);
    monitor_beat(name);
    next_cycle();
  endtask

  initial begin
    logic g;
    logic [7:0] dd;
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h3C, 8'hC3, 1'b0);
    next_cycle();
    #3;
    check("reset_state", pk(0, 0, 0, 0, 0, 3'd0, 8'h3C));
    next_cycle();
    reset = 1'b1;
    step("idle_after_reset", 0, 0, 8'h3C, 8'hC3, 0, pk(0, 0, 0, 0, 0, 3'd0, 8'h3C));

    // single requester, burst counter wrap, backpressure, handovers on request drop
    add(1, 0, 8'hA5, 8'hC3, 1, pk(0, 0, 0, 0, 0, 3'd0, 8'hA5));
    add(1, 0, 8'hA5, 8'hC3, 1, pk(1, 1, 0, 0, 1, 3'd0, 8'hA5));
    add(1, 0, 8'hA5, 8'hC3, 1, pk(1, 1, 0, 0, 1, 3'd1, 8'hA5));
    add(1, 0, 8'hA5, 8'hC3, 1, pk(1, 1, 0, 0, 1, 3'd2, 8'hA5));
    add(1, 0, 8'hA5, 8'hC3, 1, pk(1, 1, 0, 0, 1, 3'd3, 8'hA5));
    add(1, 0, 8'hA5, 8'hC3, 1, pk(1, 1, 0, 0, 1, 3'd0, 8'hA5));
    add(0, 0, 8'hA5, 8'hC3, 1, pk(0, 0, 0, 0, 1, 3'd1, 8'hA5));
    add(0, 0, 8'hA5, 8'hC3, 1, pk(0, 0, 0, 0, 0, 3'd0, 8'hA5));
    add(0, 1, 8'h11, 8'h5A, 1, pk(0, 0, 0, 0, 0, 3'd0, 8'h11));
    add(0, 1, 8'h11, 8'h5A, 1, pk(1, 0, 1, 1, 1, 3'd0, 8'h5A));
    add(0, 1, 8'h11, 8'h5A, 0, pk(1, 0, 0, 1, 1, 3'd1, 8'h5A));
    add(0, 1, 8'h11, 8'h5A, 1, pk(1, 0, 1, 1, 1, 3'd1, 8'h5A));
    add(0, 1, 8'h11, 8'h5A, 0, pk(1, 0, 0, 1, 1, 3'd2, 8'h5A));
    add(1, 1, 8'h77, 8'h5A, 1, pk(1, 0, 1, 1, 1, 3'd2, 8'h5A));
    add(1, 0, 8'h77, 8'h5A, 1, pk(0, 0, 0, 1, 1, 3'd3, 8'h5A));
    add(1, 0, 8'h77, 8'h5A, 1, pk(1, 1, 0, 0, 1, 3'd0, 8'h77));
    add(0, 1, 8'h77, 8'h99, 1, pk(0, 0, 0, 0, 1, 3'd1, 8'h77));
    add(0, 1, 8'h77, 8'h99, 1, pk(1, 0, 1, 1, 1, 3'd0, 8'h99));
    add(0, 0, 8'h77, 8'h99, 1, pk(0, 0, 0, 1, 1, 3'd1, 8'h99));
    add(0, 0, 8'h77, 8'h99, 1, pk(0, 0, 0, 0, 0, 3'd0, 8'h77));

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1,
           vecs[i].rdy, vecs[i].exp);

    // contention: round robin alternates 4-beat bursts, fixed priority keeps requester 0
    step("cont_arb", 1, 1, 8'hA0, 8'hB1, 1, pk(0, 0, 0, 0, 0, 3'd0, 8'hA0));
    for (int k = 1; k <= 16; k++) begin
      g  = RR ? 1'(((k - 1) / 4) % 2) : 1'b0;
      dd = g ? 8'hB1 : 8'hA0;
      step($sformatf("cont%0d", k), 1, 1, 8'hA0, 8'hB1, 1,
           pk(1, ~g, g, g, 1, 3'((k - 1) % 4), dd));
    end
    step("cont_drop", 0, 0, 8'hA0, 8'hB1, 1, pk(0, 0, 0, 0, 1, 3'd0, 8'hA0));
    step("cont_idle", 0, 0, 8'hA0, 8'hB1, 1, pk(0, 0, 0, 0, 0, 3'd0, 8'hA0));

    // asynchronous reset in the middle of a requester 1 burst
    step("rst_arb", 0, 1, 8'h12, 8'h34, 1, pk(0, 0, 0, 0, 0, 3'd0, 8'h12));
    step("rst_b1", 0, 1, 8'h12, 8'h34, 1, pk(1, 0, 1, 1, 1, 3'd0, 8'h34));
    step("rst_b2", 0, 1, 8'h12, 8'h34, 1, pk(1, 0, 1, 1, 1, 3'd1, 8'h34));
    drive(1'b1, 1'b1, 8'h12, 8'h34, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_same_cycle", pk(0, 0, 0, 0, 0, 3'd0, 8'h12));
    monitor_beat("rst_same_cycle");
    next_cycle();
    check("rst_held", pk(0, 0, 0, 0, 0, 3'd0, 8'h12));
    monitor_beat("rst_held");
    reset = 1'b1;
    #3;
    check("rst_release_idle", pk(0, 0, 0, 0, 0, 3'd0, 8'h12));
    next_cycle();
    step("rst_first_gnt0", 1, 1, 8'h12, 8'h34, 1, pk(1, 1, 0, 0, 1, 3'd0, 8'h12));
    step("rst_drop", 0, 0, 8'h12, 8'h34, 1, pk(0, 0, 0, 0, 1, 3'd1, 8'h12));

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d pending beats want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_channel_arbiter.md
# mux_channel_arbiter

Round-robin arbiter that shares one N_BITS output channel between two requesters by driving the select of a 2-to-1 datapath multiplexer. Each requester presents data with a request line; the arbiter grants one at a time, forwards the granted data with a valid/ready handshake, and acknowledges each consumed beat. A grant is held for bursts of up to MAX_BURST beats before the channel is offered to the other requester. Sits between two producer blocks and a single downstream consumer.

## Interface
- N_BITS, 8, data width of both requesters and the output channel
- MAX_BURST, 4, max consecutive beats per grant when the other side is waiting; must be >= 1

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Req_0  input  1  requester 0 has a beat on Data_0
- Data_0  input  N_BITS  requester 0 data
- Ack_0  output  1  requester 0 beat consumed this cycle
- Req_1  input  1  requester 1 has a beat on Data_1
- Data_1  input  N_BITS  requester 1 data
- Ack_1  output  1  requester 1 beat consumed this cycle
- Out_Valid  output  1  Out_Data holds a valid beat
- Out_Ready  input  1  consumer accepts the beat
- Out_Data  output  N_BITS  muxed data: Grant_Id ? Data_1 : Data_0
- Grant_Id  output  1  current mux select / granted requester
- Busy  output  1  a grant is active (state not IDLE)

## Operation
- FSM states: IDLE, GNT0, GNT1; registers: state, Last_Grant, Beat_Cnt (width clog2(MAX_BURST+1)).
- Reset: state=IDLE, Last_Grant=1, Beat_Cnt=0; outputs Out_Valid=0, Ack_0=0, Ack_1=0, Grant_Id=0, Busy=0, Out_Data=Data_0.
- Grant_Id=1 only in GNT1; Busy=1 in GNT0/GNT1.
- In GNTx: Out_Valid=Req_x; beat = Out_Valid & Out_Ready; Ack_x=beat; Ack of the other requester is 0. In IDLE: Out_Valid=0, no Acks.
- Requester rule: Data_x stable while Req_x=1 and Ack_x=0; Req_x may drop after any Ack_x.
- IDLE: only one Req high -> that GNTx; both high -> GNTx with x = !Last_Grant. Entering GNTx sets Last_Grant=x, Beat_Cnt=0.
- GNTx, Req_x=0: next = GNT(other) if Req_other else IDLE (direct handover, no idle bubble).
- GNTx, beat: Beat_Cnt+1. If the new count equals MAX_BURST and Req_other=1 -> GNT(other), Beat_Cnt=0; if Req_other=0 -> stay, Beat_Cnt=0 (no saturation/wrap).
- Simultaneous Req_x drop and burst expiry: handled by the Req_x=0 rule.
- Async reset mid-burst: immediate return to reset values; no beat is acknowledged in the reset cycle.

## Timing
- Arbitration latency from IDLE: Req rises in cycle n -> Out_Valid/Ack possible in cycle n+1.
- Handover GNTx -> GNTy: one cycle; the next beat from y is possible in the first cycle after the switch.
- Out_Data, Out_Valid, Ack_x are combinational from registered state plus Req/Out_Ready; no registered datapath latency.
- Sustained throughput: 1 beat/cycle while Req_x and Out_Ready are held high.

## Configuration
- ARB_ROUND_ROBIN_EN defined: behaviour as above (round robin via Last_Grant, MAX_BURST fairness on both sides).
- Not defined: fixed priority. IDLE with both requests selects GNT0. In GNT0 the burst limit is ignored: grant holds while Req_0=1. GNT1 yields to Req_0 at MAX_BURST. Last_Grant is unused.

## Test plan
- Reset: drive reset=0 mid-burst in GNT1 -> same cycle Out_Valid=0, Grant_Id=0, Busy=0; after release with Req_0=Req_1=1 -> GNT0 first.
- Single requester: Req_0=1, Data_0=0xA5, Out_Ready=1 for 6 cycles -> Grant_Id=0 throughout, Out_Data=0xA5, 5 Ack_0 pulses after the 1-cycle arbitration latency.
- Contention (RR): Req_0=Req_1=1, Out_Ready=1, MAX_BURST=4 -> 4 beats from 0, then 4 from 1, alternating; no idle cycle between bursts.
- Backpressure: in GNT1 toggle Out_Ready 1,0,1,0 -> Ack_1 only when Out_Ready=1, Data_1 held, Beat_Cnt advances 2.
- Handover on drop: GNT0, Req_0 falls with Req_1=1 -> next cycle Grant_Id=1, Out_Data=Data_1.
- Fixed priority (macro off): Req_0=Req_1=1 for 12 cycles -> Grant_Id stays 0; Ack_1 never asserts.
